jt08_adpcmb_ram: RTL and testbench

Memory bridge directly downstream of the YM2608 core's ADPCM-B RAM pins. It turns the core's `adpcmb_roe_n` / `adpcmb_wr_n` strobes into single-beat request/acknowledge transactions on a generic memory port (BRAM or SDRAM arbiter client). It returns read bytes on `adpcmb_din`. Writes are posted through a small FIFO, and reads are ordered behind all earlier writes.

---
 rtl/jt08_adpcmb_ram.sv | 208 ++++++++++++++++++++
 tb/tb_jt08_adpcmb_ram.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt08_adpcmb_ram.sv
// jt08_adpcmb_ram: bridges the YM2608 ADPCM-B RAM strobes onto a single-beat
// req/ack memory port. Writes are posted; reads wait behind queued writes.
// Build option: define JT08_ADPCMB_WRFIFO_EN for a WDEPTH-entry write FIFO;
// otherwise a single write holding register is used.
module jt08_adpcmb_ram #(
  parameter int unsigned AW     = 18,
  parameter int unsigned WDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [23:0]   adpcmb_addr,
  input  logic          adpcmb_roe_n,
  input  logic          adpcmb_wr_n,
  input  logic [7:0]    adpcmb_dout,
  output logic [7:0]    adpcmb_din,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic          wr_ovf
);

  localparam int unsigned EW = AW + 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t        state;
  logic          roe_q;
  logic          wr_q;
  logic          rd_ev;
  logic          wr_ev;
  logic [AW-1:0] ev_addr;
  logic          pop;
  logic          push_ok;
  logic          wq_empty;
  logic [AW-1:0] head_addr;
  logic [7:0]    head_data;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;
  logic          rd_issue;

  // Depth must be a power of two, at least 2
  if (WDEPTH < 2 || (WDEPTH & (WDEPTH - 1)) != 0) begin : g_bad_wdepth
    $error("jt08_adpcmb_ram: WDEPTH must be a power of two >= 2");
  end

  // Address bits above AW are ignored so addresses wrap
  if (AW < 24) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^adpcmb_addr[23:AW];
  end

  assign rd_ev   = roe_q & ~adpcmb_roe_n;
  assign wr_ev   = wr_q  & ~adpcmb_wr_n;
  assign ev_addr = adpcmb_addr[AW-1:0];
  assign pop     = (state == ST_WRITE) & mem_ack;

  // Strobe history for falling-edge event detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roe_q <= 1'b1;
      wr_q  <= 1'b1;
    end else begin
      roe_q <= adpcmb_roe_n;
      wr_q  <= adpcmb_wr_n;
    end
  end

`ifdef JT08_ADPCMB_WRFIFO_EN
  localparam int unsigned PW = $clog2(WDEPTH);

  logic [PW:0]   wptr;
  logic [PW:0]   rptr;
  logic          wq_full;
  logic [EW-1:0] fifo_mem [WDEPTH];

  assign wq_empty  = (wptr == rptr);
  assign wq_full   = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
  assign push_ok   = wr_ev & (~wq_full | pop);
  assign head_addr = fifo_mem[rptr[PW-1:0]][EW-1:8];
  assign head_data = fifo_mem[rptr[PW-1:0]][7:0];

  // FIFO pointers; the head entry stays queued until its write is acknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + (PW+1)'(1);
      if (pop)     rptr <= rptr + (PW+1)'(1);
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr[PW-1:0]] <= {ev_addr, adpcmb_dout};
  end
`else
  logic          hold_valid;
  logic [AW-1:0] hold_addr;
  logic [7:0]    hold_data;

  assign wq_empty  = ~hold_valid;
  assign push_ok   = wr_ev & (~hold_valid | pop);
  assign head_addr = hold_addr;
  assign head_data = hold_data;

  // Single write holding register, occupied until its write is acknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else if (push_ok) begin
      hold_valid <= 1'b1;
      hold_addr  <= ev_addr;
      hold_data  <= adpcmb_dout;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // A read goes out only from IDLE with no write queued or arriving
  assign rd_issue = (state == ST_IDLE) & wq_empty & ~wr_ev & (rd_pend | rd_ev);

  // Pending read: latest address wins; consumed when the read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else if (rd_ev && !rd_issue) begin
      rd_pend <= 1'b1;
      rd_addr <= ev_addr;
    end else if (rd_issue) begin
      rd_pend <= 1'b0;
    end
  end

  // Sticky overflow flag for dropped writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wr_ovf <= 1'b0;
    else if (wr_ev && !push_ok) wr_ovf <= 1'b1;
  end

  // Transaction FSM with registered request outputs and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      adpcmb_din <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!wq_empty) begin
            state     <= ST_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
          end else if (wr_ev) begin
            // Queue empty: issue straight from the bus, entry is still pushed
            state     <= ST_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= ev_addr;
            mem_wdata <= adpcmb_dout;
          end else if (rd_issue) begin
            state    <= ST_READ;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_ev ? ev_addr : rd_addr;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        ST_READ: begin
          if (mem_ack) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            adpcmb_din <= mem_rdata;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt08_adpcmb_ram.sv
// Self-checking bench for jt08_adpcmb_ram: directed cases plus random traffic
// against a queue/array reference model and a behavioural memory responder.
module tb_jt08_adpcmb_ram;

  localparam int unsigned AW     = 18;
  localparam int unsigned WDEPTH = 4;
`ifdef JT08_ADPCMB_WRFIFO_EN
  localparam int CAP = WDEPTH;
`else
  localparam int CAP = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic [23:0]   adpcmb_addr;
  logic          adpcmb_roe_n;
  logic          adpcmb_wr_n;
  logic [7:0]    adpcmb_dout;
  logic [7:0]    adpcmb_din;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;
  logic          wr_ovf;

  jt08_adpcmb_ram #(.AW(AW), .WDEPTH(WDEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adpcmb_addr  (adpcmb_addr),
    .adpcmb_roe_n (adpcmb_roe_n),
    .adpcmb_wr_n  (adpcmb_wr_n),
    .adpcmb_dout  (adpcmb_dout),
    .adpcmb_din   (adpcmb_din),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .wr_ovf       (wr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit [7:0]      tbmem [0:(1<<AW)-1];
  wr_t           exp_wq [$];
  bit            pend_v;
  logic [AW-1:0] pend_a;
  bit            m_ovf;
  // Memory responder state
  bit            busy, ack_sent, din_chk, hold_ack;
  bit            cur_we;
  logic [AW-1:0] cur_a;
  logic [7:0]    cur_d;
  logic [7:0]    din_exp;
  int            wait_cnt;
  int            lat_fix;
  int            n_wr_ack, n_rd_req;
  bit            last_rd_low, last_wr_low;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at negedge: check outputs, then decide mem_ack for the next edge
  task automatic observe();
    check("wr_ovf", 32'(wr_ovf), 32'(m_ovf));
    if (din_chk) begin
      check("din", 32'(adpcmb_din), 32'(din_exp));
      din_chk = 0;
    end
    mem_ack = 1'b0;
    if (ack_sent) begin
      check("req_drop", 32'(mem_req), 0);
      ack_sent = 0;
      busy     = 0;
    end else if (mem_req && !busy) begin
      busy     = 1;
      cur_we   = mem_we;
      cur_a    = mem_addr;
      cur_d    = mem_wdata;
      wait_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      if (mem_we) begin
        if (exp_wq.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          check("wr_addr", 32'(mem_addr), 32'(exp_wq[0].a));
          check("wr_data", 32'(mem_wdata), 32'(exp_wq[0].d));
        end
      end else begin
        n_rd_req++;
        check("rd_after_wr", 32'(exp_wq.size()), 0);
        check("rd_pend", 32'(pend_v), 1);
        check("rd_addr", 32'(mem_addr), 32'(pend_a));
        pend_v = 0;
      end
    end else if (mem_req) begin
      check("hold_we", 32'(mem_we), 32'(cur_we));
      check("hold_addr", 32'(mem_addr), 32'(cur_a));
      if (cur_we) check("hold_wdata", 32'(mem_wdata), 32'(cur_d));
    end
    if (busy && !ack_sent && !hold_ack) begin
      if (wait_cnt == 0) begin
        mem_ack  = 1'b1;
        ack_sent = 1;
        if (cur_we) begin
          tbmem[cur_a] = cur_d;
          if (exp_wq.size() > 0) void'(exp_wq.pop_front());
          n_wr_ack++;
        end else begin
          mem_rdata = tbmem[cur_a];
          din_exp   = tbmem[cur_a];
          din_chk   = 1;
        end
      end else begin
        wait_cnt--;
      end
    end
  endtask

  // Drive strobes for the next edge; a strobe only produces an event after being high
  task automatic drive(input bit do_rd, input bit do_wr, input logic [23:0] a, input logic [7:0] d);
    bit er, ew;
    er = do_rd && !last_rd_low;
    ew = do_wr && !last_wr_low;
    adpcmb_roe_n = ~er;
    adpcmb_wr_n  = ~ew;
    last_rd_low  = er;
    last_wr_low  = ew;
    adpcmb_addr  = a;
    adpcmb_dout  = d;
    if (ew) begin
      if (exp_wq.size() < CAP) exp_wq.push_back('{a[AW-1:0], d});
      else m_ovf = 1;
    end
    if (er) begin
      pend_v = 1;
      pend_a = a[AW-1:0];
    end
  endtask

  task automatic step(input bit do_rd, input bit do_wr, input logic [23:0] a, input logic [7:0] d);
    observe();
    drive(do_rd, do_wr, a, d);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (!busy && !ack_sent && !din_chk && !pend_v && exp_wq.size() == 0) return;
      step(0, 0, 24'h0, 8'h0);
    end
    check("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [23:0] ra;
    int r;
    rst_n = 1'b0;
    adpcmb_addr = '0; adpcmb_roe_n = 1'b1; adpcmb_wr_n = 1'b1; adpcmb_dout = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    pend_v = 0; m_ovf = 0; busy = 0; ack_sent = 0; din_chk = 0; hold_ack = 0;
    lat_fix = 3; n_wr_ack = 0; n_rd_req = 0; last_rd_low = 0; last_wr_low = 0;
    repeat (3) @(negedge clk);
    check("rst_din",   32'(adpcmb_din), 0);
    check("rst_req",   32'(mem_req), 0);
    check("rst_we",    32'(mem_we), 0);
    check("rst_addr",  32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_ovf",   32'(wr_ovf), 0);
    rst_n = 1'b1;
    step(0, 0, 24'h0, 8'h0);

    // Single write, request one cycle after the event
    step(0, 1, 24'h000123, 8'hA5);
    check("sw_req",   32'(mem_req), 1);
    check("sw_we",    32'(mem_we), 1);
    check("sw_addr",  32'(mem_addr), 32'h00123);
    check("sw_wdata", 32'(mem_wdata), 32'hA5);
    drain();

    // Read-after-write to the same address while the write is outstanding
    step(0, 1, 24'h03FFFF, 8'h5A);
    step(0, 0, 24'h0, 8'h0);
    step(1, 0, 24'h03FFFF, 8'h0);
    drain();
    check("raw_din", 32'(adpcmb_din), 32'h5A);

    // Address wrap
    step(0, 1, 24'hFC0010, 8'h3C);
    check("wrap_addr", 32'(mem_addr), 32'h00010);
    drain();

    // Overflow with acks held off
    hold_ack = 1;
    n0 = n_wr_ack;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 24'h001000 + 24'(i), 8'h10 + 8'(i));
      step(0, 0, 24'h0, 8'h0);
    end
    check("ovf_flag", 32'(wr_ovf), 1);
    hold_ack = 0;
    drain();
    check("ovf_count", 32'(n_wr_ack - n0), 32'(CAP));

    // Two reads before service: only the later one is issued
    hold_ack = 1;
    step(0, 1, 24'h002000, 8'h77);
    step(0, 0, 24'h0, 8'h0);
    step(1, 0, 24'h000100, 8'h0);
    step(0, 0, 24'h0, 8'h0);
    step(1, 0, 24'h000200, 8'h0);
    step(0, 0, 24'h0, 8'h0);
    n0 = n_rd_req;
    hold_ack = 0;
    drain();
    check("rd_overwrite_cnt", 32'(n_rd_req - n0), 1);

    // Simultaneous read and write events: write goes first
    step(1, 1, 24'h000345, 8'hC3);
    check("sim_req", 32'(mem_req), 1);
    check("sim_we",  32'(mem_we), 1);
    drain();
    check("sim_din", 32'(adpcmb_din), 32'hC3);

    // Random traffic over a small address set
    lat_fix = -1;
    for (int i = 0; i < 800; i++) begin
      r  = int'($urandom_range(0, 9));
      ra = {6'($urandom), 14'd0, 4'($urandom)};
      hold_ack = (i % 100) < 12;
      step(r < 2 || r == 9, (r >= 2 && r < 4) || r == 9, ra, 8'($urandom));
    end
    hold_ack = 0;
    drain();

    // Reset during an outstanding read
    hold_ack = 1;
    step(1, 0, 24'h000456, 8'h0);
    check("rst_mid_req", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    adpcmb_roe_n = 1'b1; adpcmb_wr_n = 1'b1;
    #1;
    check("rst_mid_din",   32'(adpcmb_din), 0);
    check("rst_mid_req0",  32'(mem_req), 0);
    check("rst_mid_we",    32'(mem_we), 0);
    check("rst_mid_addr",  32'(mem_addr), 0);
    check("rst_mid_wdata", 32'(mem_wdata), 0);
    check("rst_mid_ovf",   32'(wr_ovf), 0);
    exp_wq.delete();
    busy = 0; ack_sent = 0; din_chk = 0; pend_v = 0; m_ovf = 0; hold_ack = 0;
    last_rd_low = 0; last_wr_low = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_din", 32'(adpcmb_din), 0);
    check("late_ack_req", 32'(mem_req), 0);

    // Normal operation after reset
    lat_fix = 1;
    step(0, 1, 24'h000777, 8'h99);
    step(0, 0, 24'h0, 8'h0);
    step(1, 0, 24'h000777, 8'h0);
    drain();
    check("post_rst_din", 32'(adpcmb_din), 32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
